led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
Controller that owns the LED pattern memory and sequences playback to the LED pins, with a per-step hold time, one-shot or looping mode, and a host configuration write port. Sits between the SOC clock/reset (post-Clockworks `clk`/`resetn`) and `LEDS`. It replaces hard-wired pattern fetch with a programmable, start/stop-controlled player.

Parameters:
LED_W, 5, LED pattern width
DEPTH, 8, pattern memory entries; power of two, ≥2
ADDR_W, 3, log2(DEPTH)
HOLD_W, 8, per-step hold field width

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
start  in  1  pulse; begin playback at address 0
stop  in  1  pulse; abort playback
loop_en  in  1  level; sampled at wrap point
last_addr  in  ADDR_W  final step index; sampled on accepted start
cfg_we  in  1  memory write strobe
cfg_addr  in  ADDR_W  write address
cfg_pattern  in  LED_W  pattern to store
cfg_hold  in  HOLD_W  hold value to store
leds  out  LED_W  displayed pattern (registered)
step_addr  out  ADDR_W  address of the current step
busy  out  1  high in FETCH/HOLD
done  out  1  one-cycle pulse at end of one-shot playback

Behaviour:
- Async reset (resetn=0): state IDLE, leds=0, step_addr=0, busy=0, done=0, hold counter=0, latched last=0. Memory is not reset.
- Memory: DEPTH x (LED_W+HOLD_W). Synchronous write when cfg_we=1, accepted in any state. Same-cycle write and fetch at the same address: the fetch returns the old data.
- FSM states are IDLE, FETCH, HOLD, DONE.
- IDLE: if start=1 and stop=0, then latch last_addr, set step_addr=0, and go to FETCH. busy rises on the next edge.
- FETCH (1 cycle): leds<=mem[step_addr].pattern, cnt<=mem[step_addr].hold, then go to HOLD.
- HOLD: if cnt≠0, decrement cnt. If cnt=0, advance:
  - If step_addr≠last, step_addr+1 and go to FETCH.
  - Else if loop_en=1, step_addr=0 and go to FETCH.
  - Else go to DONE.
- Step period is hold+2 cycles, measured from one leds change to the next. hold=0 gives 2 cycles.
- DONE (1 cycle): done=1, busy=0 next cycle, then go to IDLE. leds keep the last pattern.
- stop=1 in any state: next state IDLE, leds=0, busy=0, no done pulse. stop has priority over start and over advance in the same cycle.
- start while busy is ignored and does not restart playback.
- last_addr=0: a single step, repeated if looping.
- Changing last_addr or loop_en mid-playback: last_addr is not used (latched copy only); loop_en is used live at the wrap point.

Optional Feature:
- Macro: LEDSEQ_BOUNCE_EN.
- Defined: adds input port bounce_en (1 bit, sampled at start) and an internal direction bit.
  - With bounce and loop: addresses run 0..last, then last-1..0, then 1..last, and so on. End addresses are not repeated. last=0 degenerates to a single step.
  - With bounce and one-shot: 0..last..0, then DONE.
- Undefined: no port, forward-only playback, identical to the base behaviour.

Decomposition:
- Package ledseq_pkg: state encoding constants (IDLE=0, FETCH=1, HOLD=2, DONE=3); default widths LED_W/ADDR_W/HOLD_W; memory word layout (pattern in low LED_W bits, hold in the upper bits).
- Sub-module ledseq_mem: the DEPTH-entry register array with synchronous write port and combinational read port. The controller FSM, counters and the bounce logic stay in led_pattern_sequencer.

Test Plan:
- Reset then idle: hold resetn=0 for 3 cycles, release. Required: leds=0, busy=0, done=0; start never pulsed → leds stay 0 for 20 cycles.
- One-shot run: load mem[0..2] = {00001/h=0, 00010/h=1, 00100/h=3}, last_addr=2, loop_en=0, start pulse.
  - leds goes 00001 (2 cyc), 00010 (3 cyc), 00100 (5 cyc).
  - Then a single-cycle done pulse, busy=0, leds held at 00100.
- Looping and stop: same memory, loop_en=1. After the third step, step_addr returns to 0 and leds=00001. A stop pulse mid-HOLD gives leds=0, busy=0 on the next edge, and no done.
- Priority: start and stop in the same cycle in IDLE → stays IDLE. start pulsed during HOLD → sequence and step timing unchanged.
- Read/write collision: cfg_we to address 1 with pattern 11111 in the same cycle FETCH reads address 1. Required: old pattern 00010 is shown; on the next loop pass 11111 is shown.
- Bounce (with LEDSEQ_BOUNCE_EN): bounce_en=1, loop_en=1, last_addr=2 → step_addr sequence 0,1,2,1,0,1,2…

Source files
------------

// File: rtl/ledseq_pkg.sv
// Shared definitions for the LED pattern sequencer: state encoding and default widths.
// Memory word layout: pattern in bits [LED_W-1:0], hold value in bits [LED_W+HOLD_W-1:LED_W].
package ledseq_pkg;

  localparam int unsigned DEF_LED_W  = 5;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ledseq_mem.sv
// Pattern memory: register array with a synchronous write port and a combinational read port.
module ledseq_mem #(
  parameter int unsigned WORD_W = 13,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata_c
);

  logic [WORD_W-1:0] mem [DEPTH];

  // No reset: contents are defined only by host writes.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A read in the same cycle as a write to that address returns the old word.
  assign rdata_c = mem[raddr];

endmodule

// File: rtl/led_pattern_sequencer.sv
// Programmable LED pattern player with per-step hold, one-shot/loop modes and a host write port.
// Optional build macro LEDSEQ_BOUNCE_EN adds the bounce_en input for ping-pong playback.
module led_pattern_sequencer
  import ledseq_pkg::*;
#(
  parameter int unsigned LED_W  = DEF_LED_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LED_W-1:0]  cfg_pattern,
  input  logic [HOLD_W-1:0] cfg_hold,
`ifdef LEDSEQ_BOUNCE_EN
  input  logic              bounce_en,
`endif
  output logic [LED_W-1:0]  leds,
  output logic [ADDR_W-1:0] step_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WORD_W = LED_W + HOLD_W;

  state_t            state;
  logic [HOLD_W-1:0] cnt;
  logic [ADDR_W-1:0] last;
  logic [WORD_W-1:0] rd_word;
  logic [ADDR_W-1:0] nxt_addr;
  logic              fin;
`ifdef LEDSEQ_BOUNCE_EN
  logic              bounce_q;
  logic              dir;
  logic              nxt_dir;
`endif

  ledseq_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (cfg_we),
    .waddr   (cfg_addr),
    .wdata   ({cfg_hold, cfg_pattern}),
    .raddr   (step_addr),
    .rdata_c (rd_word)
  );

  // Next step address at the end of a hold; fin means playback is complete.
  always_comb begin
    nxt_addr = step_addr + ADDR_W'(1);
    fin      = 1'b0;
`ifdef LEDSEQ_BOUNCE_EN
    nxt_dir  = dir;
    if (dir) begin
      if (step_addr != '0) begin
        nxt_addr = step_addr - ADDR_W'(1);
      end else if (loop_en) begin
        nxt_addr = ADDR_W'(1);
        nxt_dir  = 1'b0;
      end else begin
        fin = 1'b1;
      end
    end else if (step_addr == last) begin
      if (bounce_q && (last != '0)) begin
        nxt_addr = last - ADDR_W'(1);
        nxt_dir  = 1'b1;
      end else if (loop_en) begin
        nxt_addr = '0;
      end else begin
        fin = 1'b1;
      end
    end
`else
    if (step_addr == last) begin
      if (loop_en) nxt_addr = '0;
      else         fin      = 1'b1;
    end
`endif
  end

  // Controller FSM; stop overrides every other action.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      leds      <= '0;
      step_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      last      <= '0;
`ifdef LEDSEQ_BOUNCE_EN
      bounce_q  <= 1'b0;
      dir       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        leds  <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              last      <= last_addr;
              step_addr <= '0;
              busy      <= 1'b1;
              state     <= FETCH;
`ifdef LEDSEQ_BOUNCE_EN
              bounce_q  <= bounce_en;
              dir       <= 1'b0;
`endif
            end
          end
          FETCH: begin
            leds  <= rd_word[LED_W-1:0];
            cnt   <= rd_word[WORD_W-1:LED_W];
            state <= HOLD;
          end
          HOLD: begin
            if (cnt != '0) begin
              cnt <= cnt - HOLD_W'(1);
            end else if (fin) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              step_addr <= nxt_addr;
              state     <= FETCH;
`ifdef LEDSEQ_BOUNCE_EN
              dir       <= nxt_dir;
`endif
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: per-cycle scoreboard plus table-driven dwell checks.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

  localparam int unsigned LW = 5;
  localparam int unsigned AW = 3;
  localparam int unsigned HW = 8;

  logic          clk = 1'b0;
  logic          resetn, start, stop, loop_en, cfg_we;
  logic [AW-1:0] last_addr, cfg_addr;
  logic [LW-1:0] cfg_pattern;
  logic [HW-1:0] cfg_hold;
  logic [LW-1:0] leds;
  logic [AW-1:0] step_addr;
  logic          busy, done;
`ifdef LEDSEQ_BOUNCE_EN
  logic          bounce_en;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .last_addr   (last_addr),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_pattern (cfg_pattern),
    .cfg_hold    (cfg_hold),
`ifdef LEDSEQ_BOUNCE_EN
    .bounce_en   (bounce_en),
`endif
    .leds        (leds),
    .step_addr   (step_addr),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic [LW-1:0] leds;
    logic [AW-1:0] step;
    logic          busy;
    logic          done;
  } obs_t;

  typedef struct {
    int            addr;
    logic [LW-1:0] pat;
    logic [HW-1:0] hold;
    int            dwell;
  } vec_t;

  obs_t          exp_q[$];
  logic [LW-1:0] m_pat  [8];
  logic [HW-1:0] m_hold [8];
  vec_t          vecs   [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t cur();
    return '{leds, step_addr, busy, done};
  endfunction

  // One clock; pulse inputs last exactly one cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    start  = 1'b0;
    stop   = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic mem_write(input int a, input logic [LW-1:0] p, input logic [HW-1:0] h);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_pattern = p; cfg_hold = h;
    tick();
    m_pat[a] = p; m_hold[a] = h;
  endtask

  // Expected samples of one step: FETCH cycle (old leds) then hold+1 HOLD cycles.
  task automatic push_step(input int a, inout logic [LW-1:0] prev);
    exp_q.push_back('{prev, AW'(a), 1'b1, 1'b0});
    for (int k = 0; k <= int'(m_hold[a]); k++)
      exp_q.push_back('{m_pat[a], AW'(a), 1'b1, 1'b0});
    prev = m_pat[a];
  endtask

  task automatic push_done(input int a);
    exp_q.push_back('{m_pat[a], AW'(a), 1'b0, 1'b1});
    exp_q.push_back('{m_pat[a], AW'(a), 1'b0, 1'b0});
  endtask

  task automatic drain(input string name, input int start_at, input int we_at);
    int   idx = 0;
    obs_t e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check(name, 32'(cur()), 32'(e));
      if (idx == start_at) start = 1'b1;
      if (idx == we_at) begin
        cfg_we = 1'b1; cfg_addr = AW'(1); cfg_pattern = 5'b11111; cfg_hold = 8'd1;
      end
      idx++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] prev;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; cfg_we = 1'b0;
    last_addr = '0; cfg_addr = '0; cfg_pattern = '0; cfg_hold = '0;
`ifdef LEDSEQ_BOUNCE_EN
    bounce_en = 1'b0;
`endif
    vecs[0] = '{0, 5'b00001, 8'd0, 2};
    vecs[1] = '{1, 5'b00010, 8'd1, 3};
    vecs[2] = '{2, 5'b00100, 8'd3, 5};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(cur()), 32'(0));
    resetn = 1'b1;
    repeat (20) begin
      tick();
      check("idle_no_start", 32'({leds, busy, done}), 32'(0));
    end

    for (int i = 0; i < 3; i++) mem_write(vecs[i].addr, vecs[i].pat, vecs[i].hold);

    // One-shot, cycle by cycle
    last_addr = 3'd2; loop_en = 1'b0; start = 1'b1;
    prev = '0;
    for (int a = 0; a < 3; a++) push_step(a, prev);
    push_done(2);
    drain("oneshot", -1, -1);

    // One-shot again, dwell per table row
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int guard;
      int d;
      guard = 0;
      while (!(leds == vecs[i].pat && (busy || done)) && guard < 40) begin
        tick(); guard++;
      end
      d = 0;
      while (leds == vecs[i].pat && (busy || done) && d < 40) begin
        d++; tick();
      end
      check("dwell", 32'(d), 32'(vecs[i].dwell));
    end
    check("oneshot_end", 32'({leds, busy, done}), 32'({5'b00100, 1'b0, 1'b0}));

    // Looping, wrap to 0, then stop mid-HOLD of step 1
    loop_en = 1'b1; start = 1'b1;
    prev = 5'b00100;
    push_step(0, prev); push_step(1, prev); push_step(2, prev); push_step(0, prev);
    exp_q.push_back('{5'b00001, 3'd1, 1'b1, 1'b0});
    exp_q.push_back('{5'b00010, 3'd1, 1'b1, 1'b0});
    drain("loop", -1, -1);
    stop = 1'b1;
    tick();
    check("stop", 32'({leds, busy, done}), 32'(0));
    repeat (5) begin
      tick();
      check("no_done_after_stop", 32'({leds, busy, done}), 32'(0));
    end

    // start+stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    check("start_stop_idle", 32'({leds, busy, done}), 32'(0));
    repeat (3) begin
      tick();
      check("stays_idle", 32'({leds, busy, done}), 32'(0));
    end

    // start during HOLD is ignored
    loop_en = 1'b0; start = 1'b1;
    prev = '0;
    for (int a = 0; a < 3; a++) push_step(a, prev);
    push_done(2);
    drain("start_in_hold", 7, -1);

    // Write to address 1 while FETCH reads it: old data now, new data next pass
    loop_en = 1'b1; start = 1'b1;
    prev = 5'b00100;
    push_step(0, prev); push_step(1, prev);
    m_pat[1] = 5'b11111; m_hold[1] = 8'd1;
    push_step(2, prev); push_step(0, prev); push_step(1, prev);
    drain("collision", -1, 2);
    stop = 1'b1;
    tick();
    check("collision_stop", 32'({leds, busy, done}), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
